tlb_op_ctrl: RTL and testbench

- Sequences CP0 TLB maintenance ops (TLBR, TLBWI, TLBWR, TLBP) onto the 32-pair TLB storage.
- Drives the storage's full-entry read port (C) and write port (D).
- Owns the Random register; performs TLBP as a sequential scan over read port C.
- Asserts a lookup stall while a two-cycle pair write is in flight.

---
 rtl/tlb_op_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: runs TLBR/TLBWI/TLBWR/TLBP against the pair storage
// through its full-entry read port (C) and write port (D), and owns CP0 Random.
module tlb_op_ctrl #(
  parameter int NENT       = 32,
  parameter int RAND_RESET = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  output logic        op_ready,
  output logic        op_done,
  input  logic [4:0]  index_in,
  input  logic [4:0]  wired_in,
  input  logic        wired_we,
  input  logic [43:0] hdr_in,
  input  logic [49:0] lo_in,
  output logic [4:0]  random_out,
  output logic        tlb_we,
  output logic [4:0]  tlb_idx_d,
  output logic [49:0] tlb_entry_d,
  output logic [43:0] tlb_hdr_d,
  output logic [4:0]  tlb_idx_c,
  input  logic [49:0] tlb_entry_c,
  input  logic [43:0] tlb_hdr_c,
  output logic [49:0] rd_entry,
  output logic [43:0] rd_hdr,
  output logic [4:0]  probe_idx,
  output logic        probe_miss,
  output logic        lookup_stall
);

  // state | meaning
  // IDLE  | waiting for an op; op_ready high
  // RD    | TLBR: read port C on latched index, capture result
  // WR0   | TLBW*: write enable asserted, storage latches even half
  // WR1   | TLBW*: storage finishes odd half; lookups still stalled
  // PRB   | TLBP: scan read port C from entry 0 upward
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR0  = 3'd2;
  localparam logic [2:0] S_WR1  = 3'd3;
  localparam logic [2:0] S_PRB  = 3'd4;

  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

  localparam logic [4:0] IDX_LAST  = 5'(NENT - 1);
  localparam logic [4:0] RAND_INIT = 5'(RAND_RESET);

  logic [2:0]  state_q,      state_d;
  logic [1:0]  op_q,         op_d;
  logic [4:0]  idx_q,        idx_d;
  logic [43:0] hdr_q,        hdr_d;
  logic [49:0] lo_q,         lo_d;
  logic [4:0]  rnd_snap_q,   rnd_snap_d;
  logic [4:0]  cnt_q,        cnt_d;
  logic [4:0]  random_q,     random_d;
  logic        op_done_q,    op_done_d;
  logic [49:0] rd_entry_q,   rd_entry_d;
  logic [43:0] rd_hdr_q,     rd_hdr_d;
  logic [4:0]  probe_idx_q,  probe_idx_d;
  logic        probe_miss_q, probe_miss_d;

  logic accept;
  logic probe_hit;
  logic vpn_hi_eq;
  logic vpn_lo_eq;
  logic asid_ok;

  assign accept = op_valid && (state_q == S_IDLE);

  // Header layout: {VPN2[18:0] @43:25, ASID @24:17, G @16, PageMask @15:0}.
  // Mask and G come from the stored entry; the key is the latched hdr_in.
  always_comb begin
    vpn_hi_eq = (tlb_hdr_c[43:41] == hdr_q[43:41]);
    vpn_lo_eq = (((tlb_hdr_c[40:25] ^ hdr_q[40:25]) & ~tlb_hdr_c[15:0]) == 16'h0000);
    asid_ok   = tlb_hdr_c[16] || (tlb_hdr_c[24:17] == hdr_q[24:17]);
    probe_hit = vpn_hi_eq && vpn_lo_eq && asid_ok;
  end

  always_comb begin
    if (wired_we) begin
      random_d = RAND_INIT;
    end else if (random_q <= wired_in) begin
      random_d = IDX_LAST;
    end else begin
      random_d = random_q - 5'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    hdr_d        = hdr_q;
    lo_d         = lo_q;
    rnd_snap_d   = rnd_snap_q;
    cnt_d        = cnt_q;
    op_done_d    = 1'b0;
    rd_entry_d   = rd_entry_q;
    rd_hdr_d     = rd_hdr_q;
    probe_idx_d  = probe_idx_q;
    probe_miss_d = probe_miss_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = op_code;
          idx_d      = index_in;
          hdr_d      = hdr_in;
          lo_d       = lo_in;
          rnd_snap_d = random_q;
          cnt_d      = 5'd0;
          case (op_code)
            OP_TLBR:  state_d = S_RD;
            OP_TLBWI: state_d = S_WR0;
            OP_TLBWR: state_d = S_WR0;
            default:  state_d = S_PRB;
          endcase
        end
      end
      S_RD: begin
        rd_entry_d = tlb_entry_c;
        rd_hdr_d   = tlb_hdr_c;
        op_done_d  = 1'b1;
        state_d    = S_IDLE;
      end
      S_WR0: begin
        state_d = S_WR1;
      end
      S_WR1: begin
        op_done_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_PRB: begin
        if (probe_hit) begin
          probe_idx_d  = cnt_q;
          probe_miss_d = 1'b0;
          op_done_d    = 1'b1;
          state_d      = S_IDLE;
        end else if (cnt_q == IDX_LAST) begin
          probe_miss_d = 1'b1;
          op_done_d    = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_TLBR;
      idx_q        <= 5'd0;
      hdr_q        <= 44'd0;
      lo_q         <= 50'd0;
      rnd_snap_q   <= 5'd0;
      cnt_q        <= 5'd0;
      random_q     <= RAND_INIT;
      op_done_q    <= 1'b0;
      rd_entry_q   <= 50'd0;
      rd_hdr_q     <= 44'd0;
      probe_idx_q  <= 5'd0;
      probe_miss_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      hdr_q        <= hdr_d;
      lo_q         <= lo_d;
      rnd_snap_q   <= rnd_snap_d;
      cnt_q        <= cnt_d;
      random_q     <= random_d;
      op_done_q    <= op_done_d;
      rd_entry_q   <= rd_entry_d;
      rd_hdr_q     <= rd_hdr_d;
      probe_idx_q  <= probe_idx_d;
      probe_miss_q <= probe_miss_d;
    end
  end

  // Outside RD/PRB the read port follows the live Index for the CP0 side.
  always_comb begin
    case (state_q)
      S_RD:    tlb_idx_c = idx_q;
      S_PRB:   tlb_idx_c = cnt_q;
      default: tlb_idx_c = index_in;
    endcase
  end

  assign op_ready     = (state_q == S_IDLE);
  assign op_done      = op_done_q;
  assign random_out   = random_q;
  assign tlb_we       = (state_q == S_WR0);
  assign tlb_idx_d    = (op_q == OP_TLBWR) ? rnd_snap_q : idx_q;
  assign tlb_entry_d  = lo_q;
  assign tlb_hdr_d    = hdr_q;
  assign rd_entry     = rd_entry_q;
  assign rd_hdr       = rd_hdr_q;
  assign probe_idx    = probe_idx_q;
  assign probe_miss   = probe_miss_q;
  assign lookup_stall = (state_q == S_WR0) || (state_q == S_WR1);

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl with a behavioural TLB storage and
// reference models for Random and the TLBP first-match search.
module tb_tlb_op_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic        op_ready;
  logic        op_done;
  logic [4:0]  index_in = 5'd0;
  logic [4:0]  wired_in = 5'd0;
  logic        wired_we = 1'b0;
  logic [43:0] hdr_in = 44'd0;
  logic [49:0] lo_in = 50'd0;
  logic [4:0]  random_out;
  logic        tlb_we;
  logic [4:0]  tlb_idx_d;
  logic [49:0] tlb_entry_d;
  logic [43:0] tlb_hdr_d;
  logic [4:0]  tlb_idx_c;
  logic [49:0] tlb_entry_c;
  logic [43:0] tlb_hdr_c;
  logic [49:0] rd_entry;
  logic [43:0] rd_hdr;
  logic [4:0]  probe_idx;
  logic        probe_miss;
  logic        lookup_stall;

  int checks = 0;
  int failures = 0;

  logic [43:0] mem_hdr [32];
  logic [49:0] mem_ent [32];
  logic [4:0]  exp_rand;
  logic [4:0]  last_pidx;

  tlb_op_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .op_done(op_done), .index_in(index_in),
    .wired_in(wired_in), .wired_we(wired_we), .hdr_in(hdr_in), .lo_in(lo_in),
    .random_out(random_out), .tlb_we(tlb_we), .tlb_idx_d(tlb_idx_d),
    .tlb_entry_d(tlb_entry_d), .tlb_hdr_d(tlb_hdr_d), .tlb_idx_c(tlb_idx_c),
    .tlb_entry_c(tlb_entry_c), .tlb_hdr_c(tlb_hdr_c), .rd_entry(rd_entry),
    .rd_hdr(rd_hdr), .probe_idx(probe_idx), .probe_miss(probe_miss),
    .lookup_stall(lookup_stall)
  );

  always #5 clk = ~clk;

  assign tlb_hdr_c   = mem_hdr[tlb_idx_c];
  assign tlb_entry_c = mem_ent[tlb_idx_c];

  always @(posedge clk) begin
    if (tlb_we) begin
      mem_hdr[tlb_idx_d] = tlb_hdr_d;
      mem_ent[tlb_idx_d] = tlb_entry_d;
    end
  end

  // Random reference: reset/Wired write -> 31, wrap at or below Wired, else count down.
  always @(posedge clk) begin
    if (rst || wired_we) exp_rand <= 5'd31;
    else if (exp_rand <= wired_in) exp_rand <= 5'd31;
    else exp_rand <= exp_rand - 5'd1;
  end

  function automatic logic [43:0] mk_hdr(input logic [18:0] vpn, input logic [7:0] asid,
                                         input logic g, input logic [15:0] mask);
    return {vpn, asid, g, mask};
  endfunction

  function automatic int probe_ref(input logic [43:0] key);
    for (int i = 0; i < 32; i++) begin
      logic [43:0] h;
      logic vpn_ok, asid_ok;
      h = mem_hdr[i];
      vpn_ok = (h[43:41] == key[43:41]);
      for (int b = 0; b < 16; b++)
        if (!h[b] && (h[25+b] != key[25+b])) vpn_ok = 1'b0;
      asid_ok = h[16] || (h[24:17] == key[24:17]);
      if (vpn_ok && asid_ok) return i;
    end
    return -1;
  endfunction

  function automatic logic [49:0] rnd50();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[49:0];
  endfunction

  function automatic logic [43:0] rnd44();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[43:0];
  endfunction

  task automatic fill_nomatch();
    for (int i = 0; i < 32; i++) begin
      mem_hdr[i] = mk_hdr({3'b111, 16'(i)}, 8'hAA, 1'b0, 16'h0000);
      mem_ent[i] = rnd50();
    end
  endtask

  // Issues one op in the next cycle (cycle 0) and observes until op_done.
  task automatic run_op(input logic [1:0] code, input logic [4:0] idx,
                        input logic [43:0] hdr, input logic [49:0] lo,
                        output int done_cyc, output logic [4:0] snap,
                        output logic [63:0] we_mask, output logic [63:0] stall_mask,
                        output logic [4:0] widx, output logic [43:0] whdr,
                        output logic [49:0] went);
    @(negedge clk);
    op_valid = 1'b1; op_code = code; index_in = idx; hdr_in = hdr; lo_in = lo;
    snap = exp_rand;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 2'($urandom()); index_in = 5'($urandom());
    hdr_in = rnd44(); lo_in = rnd50();
    done_cyc = -1; we_mask = '0; stall_mask = '0; widx = '0; whdr = '0; went = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (tlb_we) begin
        we_mask[c] = 1'b1; widx = tlb_idx_d; whdr = tlb_hdr_d; went = tlb_entry_d;
      end
      if (lookup_stall) stall_mask[c] = 1'b1;
      if (op_done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wired_in = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({op_done, tlb_we, lookup_stall, probe_miss} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b want=0000", {op_done, tlb_we, lookup_stall, probe_miss});
    end
    checks++;
    if (rd_entry !== 50'd0 || rd_hdr !== 44'd0 || probe_idx !== 5'd0) begin
      failures++; $display("FAIL reset_results entry=%h hdr=%h pidx=%0d want 0", rd_entry, rd_hdr, probe_idx);
    end
    checks++;
    if (op_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", op_ready);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (random_out !== 5'(31 - i)) begin
        failures++; $display("FAIL reset_random step=%0d got=%0d want=%0d", i, random_out, 31 - i);
      end
    end
    last_pidx = 5'd0;
  endtask

  task automatic test_wired();
    logic [4:0] seq [5];
    seq[0] = 5'd31; seq[1] = 5'd30; seq[2] = 5'd29; seq[3] = 5'd31; seq[4] = 5'd30;
    @(negedge clk);
    rst = 1'b1; wired_in = 5'd29;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (random_out !== seq[i]) begin
        failures++; $display("FAIL wired29 step=%0d got=%0d want=%0d", i, random_out, seq[i]);
      end
    end
    wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
    checks++;
    if (random_out !== 5'd31) begin
      failures++; $display("FAIL wired_we got=%0d want=31", random_out);
    end
    wired_in = 5'd0;
  endtask

  task automatic test_write_read();
    int dc; logic [4:0] sn, wi; logic [63:0] wm, sm; logic [43:0] wh, hdr; logic [49:0] we_e, lo;
    hdr = mk_hdr(19'h01234, 8'd5, 1'b0, 16'h0000);
    lo = rnd50();
    run_op(2'b01, 5'd7, hdr, lo, dc, sn, wm, sm, wi, wh, we_e);
    checks++;
    if (wm !== 64'h2) begin failures++; $display("FAIL wi_we_cycles got=%h want=2", wm); end
    checks++;
    if (wi !== 5'd7) begin failures++; $display("FAIL wi_idx got=%0d want=7", wi); end
    checks++;
    if (wh !== hdr || we_e !== lo) begin
      failures++; $display("FAIL wi_data hdr=%h/%h ent=%h/%h", wh, hdr, we_e, lo);
    end
    checks++;
    if (sm !== 64'h6) begin failures++; $display("FAIL wi_stall got=%h want=6", sm); end
    checks++;
    if (dc !== 3) begin failures++; $display("FAIL wi_done got=%0d want=3", dc); end
    run_op(2'b00, 5'd7, rnd44(), rnd50(), dc, sn, wm, sm, wi, wh, we_e);
    checks++;
    if (dc !== 2) begin failures++; $display("FAIL rd_done got=%0d want=2", dc); end
    checks++;
    if (rd_entry !== lo || rd_hdr !== hdr) begin
      failures++; $display("FAIL rd_data entry=%h/%h hdr=%h/%h", rd_entry, lo, rd_hdr, hdr);
    end
    checks++;
    if (wm !== 64'h0 || sm !== 64'h0) begin
      failures++; $display("FAIL rd_no_write we=%h stall=%h want 0", wm, sm);
    end
  endtask

  task automatic test_probe_priority();
    int dc; logic [4:0] sn, wi; logic [63:0] wm, sm; logic [43:0] wh, key; logic [49:0] we_e;
    fill_nomatch();
    key = mk_hdr(19'h01234, 8'd5, 1'b0, 16'h0000);
    mem_hdr[3] = mk_hdr(19'h01234, 8'd9, 1'b1, 16'h0000);
    mem_hdr[9] = mk_hdr(19'h01234, 8'd5, 1'b0, 16'h0000);
    run_op(2'b11, 5'd0, key, rnd50(), dc, sn, wm, sm, wi, wh, we_e);
    checks++;
    if (dc !== 5) begin failures++; $display("FAIL prb_prio_done got=%0d want=5", dc); end
    checks++;
    if (probe_idx !== 5'd3 || probe_miss !== 1'b0) begin
      failures++; $display("FAIL prb_prio idx=%0d miss=%b want 3/0", probe_idx, probe_miss);
    end
    last_pidx = 5'd3;
  endtask

  task automatic test_probe_mask();
    int dc; logic [4:0] sn, wi; logic [63:0] wm, sm; logic [43:0] wh, key; logic [49:0] we_e;
    fill_nomatch();
    mem_hdr[20] = mk_hdr(19'h01234 ^ 19'h00020, 8'd5, 1'b0, 16'h0020);
    key = mk_hdr(19'h01234, 8'd5, 1'b0, 16'h0000);
    run_op(2'b11, 5'd0, key, rnd50(), dc, sn, wm, sm, wi, wh, we_e);
    checks++;
    if (dc !== 22) begin failures++; $display("FAIL prb_mask_done got=%0d want=22", dc); end
    checks++;
    if (probe_idx !== 5'd20 || probe_miss !== 1'b0) begin
      failures++; $display("FAIL prb_mask idx=%0d miss=%b want 20/0", probe_idx, probe_miss);
    end
    key = mk_hdr(19'h05555, 8'd5, 1'b0, 16'h0000);
    run_op(2'b11, 5'd0, key, rnd50(), dc, sn, wm, sm, wi, wh, we_e);
    checks++;
    if (dc !== 33) begin failures++; $display("FAIL prb_miss_done got=%0d want=33", dc); end
    checks++;
    if (probe_miss !== 1'b1 || probe_idx !== 5'd20) begin
      failures++; $display("FAIL prb_miss miss=%b idx=%0d want 1/20", probe_miss, probe_idx);
    end
    last_pidx = 5'd20;
  endtask

  task automatic test_probe_random();
    int dc, ex, j; logic [4:0] sn, wi; logic [63:0] wm, sm; logic [43:0] wh, key; logic [49:0] we_e;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 32; i++) begin
        mem_hdr[i] = mk_hdr({2'b00, 1'($urandom_range(0, 1)), 16'($urandom())},
                            8'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                            16'($urandom() & $urandom() & $urandom()));
        mem_ent[i] = rnd50();
      end
      j = $urandom_range(0, 31);
      key = mem_hdr[j];
      key[24:17] = 8'($urandom_range(0, 3));
      if (it % 3 == 2) key[43:41] = 3'b100;
      key[16:0] = 17'($urandom());
      ex = probe_ref(key);
      run_op(2'b11, 5'($urandom()), key, rnd50(), dc, sn, wm, sm, wi, wh, we_e);
      if (ex >= 0) begin
        checks++;
        if (dc !== ex + 2 || probe_idx !== 5'(ex) || probe_miss !== 1'b0) begin
          failures++; $display("FAIL prb_rand it=%0d done=%0d idx=%0d miss=%b want done=%0d idx=%0d miss=0",
                               it, dc, probe_idx, probe_miss, ex + 2, ex);
        end
        last_pidx = 5'(ex);
      end else begin
        checks++;
        if (dc !== 33 || probe_idx !== last_pidx || probe_miss !== 1'b1) begin
          failures++; $display("FAIL prb_rand_miss it=%0d done=%0d idx=%0d miss=%b want done=33 idx=%0d miss=1",
                               it, dc, probe_idx, probe_miss, last_pidx);
        end
      end
    end
  endtask

  task automatic test_random_write();
    int dc; logic [4:0] sn, wi, idx, exp_idx; logic [63:0] wm, sm; logic [43:0] wh, hdr;
    logic [49:0] we_e, lo; logic [1:0] code;
    for (int it = 0; it < 5; it++) begin
      @(negedge clk);
      wired_in = 5'($urandom_range(0, 20));
      checks++;
      if (random_out !== exp_rand) begin
        failures++; $display("FAIL random_track got=%0d want=%0d", random_out, exp_rand);
      end
      code = (it % 2 == 0) ? 2'b10 : 2'b01;
      idx = 5'($urandom()); hdr = rnd44(); lo = rnd50();
      run_op(code, idx, hdr, lo, dc, sn, wm, sm, wi, wh, we_e);
      exp_idx = (code == 2'b10) ? sn : idx;
      checks++;
      if (wm !== 64'h2 || wi !== exp_idx || dc !== 3) begin
        failures++; $display("FAIL wr_rand it=%0d we=%h idx=%0d done=%0d want we=2 idx=%0d done=3",
                             it, wm, wi, dc, exp_idx);
      end
      run_op(2'b00, exp_idx, rnd44(), rnd50(), dc, sn, wm, sm, wi, wh, we_e);
      checks++;
      if (rd_entry !== lo || rd_hdr !== hdr || dc !== 2) begin
        failures++; $display("FAIL rd_rand it=%0d entry=%h/%h hdr=%h/%h done=%0d",
                             it, rd_entry, lo, rd_hdr, hdr, dc);
      end
    end
    wired_in = 5'd0;
  endtask

  task automatic test_back_to_back();
    logic [49:0] lo; logic [43:0] hdr;
    lo = rnd50(); hdr = rnd44();
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b01; index_in = 5'd4; hdr_in = hdr; lo_in = lo;
    @(posedge clk); #1;
    op_code = 2'b00;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b0) begin failures++; $display("FAIL b2b_busy1 ready=%b want=0", op_ready); end
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b0 || op_done !== 1'b0) begin
      failures++; $display("FAIL b2b_busy2 ready=%b done=%b want 0/0", op_ready, op_done);
    end
    @(negedge clk);
    checks++;
    if (op_done !== 1'b1 || op_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_done_ready done=%b ready=%b want 1/1", op_done, op_ready);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (op_done !== 1'b0 || op_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_rd_busy done=%b ready=%b want 0/0", op_done, op_ready);
    end
    @(negedge clk);
    checks++;
    if (op_done !== 1'b1 || rd_entry !== lo || rd_hdr !== hdr) begin
      failures++; $display("FAIL b2b_rd done=%b entry=%h/%h hdr=%h/%h", op_done, rd_entry, lo, rd_hdr, hdr);
    end
  endtask

  task automatic test_reset_midop();
    int found;
    found = 0;
    wired_in = 5'd0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (exp_rand == 5'd12) begin found = 1; break; end
    end
    checks++;
    if (found == 0 || random_out !== 5'd12) begin
      failures++; $display("FAIL midop_wait found=%0d random=%0d want 12", found, random_out);
    end
    op_valid = 1'b1; op_code = 2'b10; index_in = 5'd3; hdr_in = rnd44(); lo_in = rnd50();
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tlb_we !== 1'b1 || tlb_idx_d !== 5'd12) begin
      failures++; $display("FAIL midop_wr0 we=%b idx=%0d want 1/12", tlb_we, tlb_idx_d);
    end
    @(negedge clk);
    checks++;
    if (lookup_stall !== 1'b1 || tlb_we !== 1'b0) begin
      failures++; $display("FAIL midop_wr1 stall=%b we=%b want 1/0", lookup_stall, tlb_we);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (op_done !== 1'b0 || op_ready !== 1'b1 || lookup_stall !== 1'b0) begin
      failures++; $display("FAIL midop_idle done=%b ready=%b stall=%b want 0/1/0", op_done, op_ready, lookup_stall);
    end
    checks++;
    if (random_out !== 5'd31) begin
      failures++; $display("FAIL midop_random got=%0d want=31", random_out);
    end
    @(negedge clk);
    checks++;
    if (op_done !== 1'b0) begin failures++; $display("FAIL midop_nodone got=%b want=0", op_done); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_hdr[i] = 44'd0;
      mem_ent[i] = 50'd0;
    end
    test_reset();
    test_wired();
    test_write_read();
    test_probe_priority();
    test_probe_mask();
    test_probe_random();
    test_random_write();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
